// File: rtl/composite_pkg.sv
// -----------------------------------------------------------------------------
// composite_pkg
// Shared constants and helpers for the composite video encoder.
//   - BT.601-style luma coefficients (sum to 256) and U/V scale factors
//   - quarterTurn(): sine-table index offset that turns a sine read into cosine
//   - replicate8(): MSB-first bit replication of a narrow colour to 8 bits
//   - sineSample(): elaboration-time sine table entry, signed 8-bit, peak 127
// No ports (package).
// -----------------------------------------------------------------------------
package composite_pkg;

   localparam int unsigned COEF_YR = 77;
   localparam int unsigned COEF_YG = 150;
   localparam int unsigned COEF_YB = 29;
   localparam int unsigned COEF_U  = 126;
   localparam int unsigned COEF_V  = 224;

   // Index offset of a quarter turn in a table of 2^lutW entries.
   function automatic int unsigned quarterTurn(input int unsigned lutW);
      return 1 << (lutW - 2);
   endfunction

   // Repeat the width-bit value from its MSB downward until 8 bits are filled,
   // so full scale maps to 255 and zero to 0 (3'b101 -> 8'b10110110).
   function automatic logic [7:0] replicate8(input logic [7:0] val, input int unsigned width);
      logic [7:0] res;
      logic [2:0] bitSel;
      res = '0;
      for (int i = 0; i < 8; i++) begin
         bitSel = 3'(width - 1 - (i % width));
         res    = {res[6:0], val[bitSel]};
      end
      return res;
   endfunction

   // Rounded 127*sin(2*pi*idx/2^lutW); only evaluated to build the ROM contents.
   function automatic logic signed [7:0] sineSample(input int idx, input int lutW);
      real ang;
      real s;
      ang = 6.283185307179586 * real'(idx) / real'(1 << lutW);
      s   = 127.0 * $sin(ang);
      if (s >= 0.0)
         return 8'($rtoi(s + 0.5));
      else
         return 8'(-$rtoi(0.5 - s));
   endfunction

endpackage

// File: rtl/composite_sin_lut.sv
// -----------------------------------------------------------------------------
// composite_sin_lut
// Dual-read sine ROM with registered outputs. One read port returns sin at the
// given index, the other returns cos by reading a quarter turn further on.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (clears the output registers)
//   sinIdx   in   LUT_W-bit phase index
//   sinVal   out  signed 8-bit sin, one cycle after sinIdx
//   cosVal   out  signed 8-bit cos, one cycle after sinIdx
// -----------------------------------------------------------------------------
module composite_sin_lut
   import composite_pkg::*;
#(
   parameter int LUT_W = 6
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [LUT_W-1:0]        sinIdx,
   output logic signed [7:0]       sinVal,
   output logic signed [7:0]       cosVal
);

   localparam int DEPTH = 1 << LUT_W;
   localparam logic [LUT_W-1:0] QUARTER = LUT_W'(quarterTurn(LUT_W));

   logic signed [7:0] romData [DEPTH];
   logic [LUT_W-1:0]  cosIdx;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
         assign romData[gi] = sineSample(gi, LUT_W);
      end
   endgenerate

   // Natural LUT_W-bit wrap keeps the cosine read inside the table.
   assign cosIdx = sinIdx + QUARTER;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sinVal <= '0;
         cosVal <= '0;
      end else begin
         sinVal <= romData[sinIdx];
         cosVal <= romData[cosIdx];
      end
   end

endmodule

// File: rtl/composite_encoder.sv
// -----------------------------------------------------------------------------
// composite_encoder
// RGB to composite video encoder: luma plus quadrature-modulated chroma on a
// DDS subcarrier, colorburst insertion, saturated output. Three pipeline
// stages, no stall, every qualifier delayed with the data.
// Optional PAL support when macro COMPOSITE_PAL_EN is defined (adds pal_mode
// and the line-alternating V switch); without it the encoder is NTSC only.
// Ports:
//   clk           in   clock
//   reset_n       in   asynchronous active-low reset
//   phase_inc     in   subcarrier tuning word, added to the accumulator each cycle
//   r / g / b     in   pixel colour
//   sync_level    in   sync/blank/black base level
//   active        in   visible pixel qualifier
//   colorburst    in   burst window qualifier (wins over active)
//   line_start    in   line start pulse (PAL V switch)
//   frame_start   in   frame start pulse (phase and V switch restart)
//   pal_mode      in   PAL select (COMPOSITE_PAL_EN only)
//   composite     out  encoded sample, 3 cycles after its inputs
//   burst_active  out  colorburst aligned with composite
// -----------------------------------------------------------------------------
module composite_encoder
   import composite_pkg::*;
#(
   parameter int R_W       = 3,
   parameter int G_W       = 3,
   parameter int B_W       = 2,
   parameter int OUT_W     = 8,
   parameter int PHASE_W   = 32,
   parameter int LUT_W     = 6,
   parameter int BURST_AMP = 36
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [PHASE_W-1:0] phase_inc,
   input  logic [R_W-1:0]     r,
   input  logic [G_W-1:0]     g,
   input  logic [B_W-1:0]     b,
   input  logic [OUT_W-1:0]   sync_level,
   input  logic               active,
   input  logic               colorburst,
   input  logic               line_start,
   input  logic               frame_start,
`ifdef COMPOSITE_PAL_EN
   input  logic               pal_mode,
`endif
   output logic [OUT_W-1:0]   composite,
   output logic               burst_active
);

   localparam int SW = OUT_W + 3;   // signed width of the output sums
   localparam int SH = OUT_W - 8;   // scale 8-bit quantities to OUT_W
   localparam logic signed [17:0] COEF_U_S  = 18'(COEF_U);
   localparam logic signed [17:0] COEF_V_S  = 18'(COEF_V);
   localparam logic signed [17:0] BURST_K   = 18'(BURST_AMP);
   localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << OUT_W) - 1);

   // ---------------- phase accumulator ----------------
   logic [PHASE_W-1:0] acc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         acc <= '0;
      else if (frame_start)
         acc <= '0;
      else
         acc <= acc + phase_inc;
   end

   // ---------------- stage 1: inputs, phase index, luma ----------------
   logic [7:0]  r8, g8, b8, y8;
   logic [15:0] yAcc;

   assign r8   = replicate8(8'(r), R_W);
   assign g8   = replicate8(8'(g), G_W);
   assign b8   = replicate8(8'(b), B_W);
   assign yAcc = 16'(COEF_YR) * 16'(r8) + 16'(COEF_YG) * 16'(g8) + 16'(COEF_YB) * 16'(b8);
   assign y8   = 8'(yAcc >> 8);

   logic [LUT_W-1:0] idxS1;
   logic [7:0]       y8S1, r8S1, b8S1;
   logic [OUT_W-1:0] syncS1;
   logic             activeS1, burstS1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idxS1    <= '0;
         y8S1     <= '0;
         r8S1     <= '0;
         b8S1     <= '0;
         syncS1   <= '0;
         activeS1 <= 1'b0;
         burstS1  <= 1'b0;
      end else begin
         idxS1    <= acc[PHASE_W-1 -: LUT_W];
         y8S1     <= y8;
         r8S1     <= r8;
         b8S1     <= b8;
         syncS1   <= sync_level;
         activeS1 <= active;
         burstS1  <= colorburst;
      end
   end

   // ---------------- PAL V switch ----------------
`ifdef COMPOSITE_PAL_EN
   logic vsw, vswNext, vswS1, vswS2;

   always_comb begin
      vswNext = vsw;
      if (frame_start)
         vswNext = 1'b0;
      else if (line_start && pal_mode)
         vswNext = ~vsw;
   end

   // The pipeline takes the post-update value so the line_start sample already
   // belongs to the new line's phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vsw   <= 1'b0;
         vswS1 <= 1'b0;
         vswS2 <= 1'b0;
      end else begin
         vsw   <= vswNext;
         vswS1 <= vswNext;
         vswS2 <= vswS1;
      end
   end
`else
   logic unusedLineStart;
   assign unusedLineStart = line_start;
`endif

   // ---------------- stage 2: colour difference, table lookup ----------------
   logic signed [9:0]  bMinusY, rMinusY, uVal, vVal, vOut;
   logic signed [17:0] uProd, vProd;

   assign bMinusY = $signed({2'b00, b8S1}) - $signed({2'b00, y8S1});
   assign rMinusY = $signed({2'b00, r8S1}) - $signed({2'b00, y8S1});
   assign uProd   = COEF_U_S * 18'(bMinusY);
   assign vProd   = COEF_V_S * 18'(rMinusY);
   assign uVal    = 10'(uProd >>> 8);
   assign vVal    = 10'(vProd >>> 8);
`ifdef COMPOSITE_PAL_EN
   assign vOut    = vswS1 ? -vVal : vVal;
`else
   assign vOut    = vVal;
`endif

   logic signed [9:0] uS2, vS2;
   logic signed [7:0] sinS2, cosS2;
   logic [7:0]        y8S2;
   logic [OUT_W-1:0]  syncS2;
   logic              activeS2, burstS2;

   composite_sin_lut #(
      .LUT_W (LUT_W)
   ) uSinLut (
      .clk     (clk),
      .reset_n (reset_n),
      .sinIdx  (idxS1),
      .sinVal  (sinS2),
      .cosVal  (cosS2)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uS2      <= '0;
         vS2      <= '0;
         y8S2     <= '0;
         syncS2   <= '0;
         activeS2 <= 1'b0;
         burstS2  <= 1'b0;
      end else begin
         uS2      <= uVal;
         vS2      <= vOut;
         y8S2     <= y8S1;
         syncS2   <= syncS1;
         activeS2 <= activeS1;
         burstS2  <= burstS1;
      end
   end

   // ---------------- stage 3: modulate, select, saturate ----------------
   logic signed [17:0]   chromaSum;
   logic signed [8:0]    burstSin;
   logic signed [17:0]   burstProd, burstMag, burstLvl;
   logic signed [SW-1:0] syncTerm, lumaTerm, chromaTerm, burstTerm, total;
   logic [OUT_W-1:0]     compNext;

   assign chromaSum = 18'(uS2) * 18'(sinS2) + 18'(vS2) * 18'(cosS2);

`ifdef COMPOSITE_PAL_EN
   // 135 deg = (cos - sin)/sqrt2, 225 deg = (-cos - sin)/sqrt2; 181/256 ~ 1/sqrt2.
   logic signed [9:0]  palMix;
   logic signed [17:0] palProd;
   assign palMix   = vswS2 ? (-10'(cosS2) - 10'(sinS2)) : (10'(cosS2) - 10'(sinS2));
   assign palProd  = 18'(palMix) * 18'sd181;
   assign burstSin = 9'(palProd >>> 8);
`else
   assign burstSin = -(9'(sinS2));
`endif

   // Burst level rounds toward zero so the burst swings symmetrically about
   // the blanking level (+35 / -35 for the default amplitude).
   assign burstProd = BURST_K * 18'(burstSin);
   assign burstMag  = burstProd[17] ? -burstProd : burstProd;
   assign burstLvl  = burstProd[17] ? -(burstMag >>> 7) : (burstMag >>> 7);

   assign syncTerm   = $signed(SW'(syncS2));
   assign lumaTerm   = $signed(SW'(y8S2)) <<< SH;
   assign chromaTerm = SW'(chromaSum >>> 7) <<< SH;
   assign burstTerm  = SW'(burstLvl) <<< SH;

   always_comb begin
      total = syncTerm;
      if (burstS2)
         total = syncTerm + burstTerm;
      else if (activeS2)
         total = syncTerm + lumaTerm + chromaTerm;
   end

   always_comb begin
      compNext = OUT_W'(total);
      if (total < 0)
         compNext = '0;
      else if (total > SAT_MAX)
         compNext = '1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         composite    <= '0;
         burst_active <= 1'b0;
      end else begin
         composite    <= compNext;
         burst_active <= burstS2;
      end
   end

endmodule

// File: tb/tb_composite_encoder.sv
// -----------------------------------------------------------------------------
// tb_composite_encoder
// Directed vectors with hand-computed composite values for the default
// parameters (3/3/2 colour, 8-bit output, 64-entry sine table, burst amp 36).
// Subcarrier runs at a quarter turn per cycle so phases cycle 0/90/180/270.
// Expected values travel through a 3-deep queue matching the pipeline latency.
// -----------------------------------------------------------------------------
module tb_composite_encoder;

   logic        clk = 1'b0;
   logic        resetN;
   logic [31:0] phaseInc;
   logic [2:0]  r, g;
   logic [1:0]  b;
   logic [7:0]  syncLevel;
   logic        active, colorburst, lineStart, frameStart;
`ifdef COMPOSITE_PAL_EN
   logic        palMode = 1'b0;
`endif
   logic [7:0]  composite;
   logic        burstActive;

   int compared   = 0;
   int mismatched = 0;

   int    expComp[$];
   logic  expBurst[$];
   string expTag[$];

   // Hand-computed sequences, one entry per subcarrier phase 0/90/180/270.
   int burstSeq[4]  = '{60, 25, 60, 95};     // 60 + {0,-35,0,+35}
   int yellowSeq[4] = '{255, 174, 255, 255};  // Y8=226 U=-112 V=25, sync 60
   int blueSeq[4]   = '{3, 138, 52, 0};       // Y8=28 U=111 V=-25, sync 0

   always #5 clk = ~clk;

   composite_encoder dut (
      .clk          (clk),
      .reset_n      (resetN),
      .phase_inc    (phaseInc),
      .r            (r),
      .g            (g),
      .b            (b),
      .sync_level   (syncLevel),
      .active       (active),
      .colorburst   (colorburst),
      .line_start   (lineStart),
      .frame_start  (frameStart),
`ifdef COMPOSITE_PAL_EN
      .pal_mode     (palMode),
`endif
      .composite    (composite),
      .burst_active (burstActive)
   );

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply one input vector for one cycle; check the vector issued 3 cycles ago.
   task automatic drive(input int rv, input int gv, input int bv, input int sync,
                        input logic act, input logic cb, input logic fs,
                        input int expVal, input string tag);
      int    c;
      logic  eb;
      string t;
      r          = 3'(rv);
      g          = 3'(gv);
      b          = 2'(bv);
      syncLevel  = 8'(sync);
      active     = act;
      colorburst = cb;
      frameStart = fs;
      lineStart  = fs;
      tick();
      expComp.push_back(expVal);
      expBurst.push_back(cb);
      expTag.push_back(tag);
      if (expComp.size() == 3) begin
         c  = expComp.pop_front();
         eb = expBurst.pop_front();
         t  = expTag.pop_front();
         $display("txn %-14s composite=%0d burst_active=%0b (want %0d/%0b)",
                  t, composite, burstActive, c, eb);
         checkVal({t, ".composite"}, 32'(composite), 32'(c));
         checkVal({t, ".burst"}, 32'(burstActive), 32'(eb));
      end
   endtask

   // Hold reset with toggling inputs; outputs must stay cleared. On release the
   // first two samples come from the cleared pipeline and must read zero.
   task automatic resetPhase(input int cycles, input string name);
      resetN = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         r          = 3'(i + 5);
         g          = 3'(i * 3);
         b          = 2'(i);
         syncLevel  = 8'(50 + 7 * i);
         active     = i[0];
         colorburst = ~i[0];
         frameStart = i[1];
         lineStart  = 1'b1;
         tick();
         $display("txn %s%0d composite=%0d burst_active=%0b", name, i, composite, burstActive);
         checkVal($sformatf("%s%0d.composite", name, i), 32'(composite), 32'd0);
         checkVal($sformatf("%s%0d.burst", name, i), 32'(burstActive), 32'd0);
      end
      expComp.delete();
      expBurst.delete();
      expTag.delete();
      for (int i = 0; i < 2; i++) begin
         expComp.push_back(0);
         expBurst.push_back(1'b0);
         expTag.push_back($sformatf("%sFill%0d", name, i));
      end
      resetN = 1'b1;
   endtask

   initial begin
      resetN     = 1'b0;
      phaseInc   = 32'h4000_0000;
      r          = '0;
      g          = '0;
      b          = '0;
      syncLevel  = '0;
      active     = 1'b0;
      colorburst = 1'b0;
      lineStart  = 1'b0;
      frameStart = 1'b0;
      tick();
      resetPhase(3, "reset");

      // Blanking: sync level passes straight through.
      drive(0, 0, 0, 60, 1'b0, 1'b0, 1'b0, 60, "blank0");
      drive(0, 0, 0, 60, 1'b0, 1'b0, 1'b0, 60, "blank1");
      drive(0, 0, 0, 60, 1'b0, 1'b0, 1'b1, 60, "frameStart0");

      // Burst: two full subcarrier periods.
      for (int k = 0; k < 8; k++)
         drive(0, 0, 0, 60, 1'b0, 1'b1, 1'b0, burstSeq[k % 4], $sformatf("burst%0d", k));

      // Burst wins over active.
      for (int k = 0; k < 4; k++)
         drive(7, 7, 3, 60, 1'b1, 1'b1, 1'b0, burstSeq[k], $sformatf("precedence%0d", k));

      // White: no chroma, luma saturates at 255.
      for (int k = 0; k < 4; k++)
         drive(7, 7, 3, 60, 1'b1, 1'b0, 1'b0, 255, $sformatf("white%0d", k));

      // Black: composite equals sync level.
      for (int k = 0; k < 2; k++)
         drive(0, 0, 0, 60, 1'b1, 1'b0, 1'b0, 60, $sformatf("black%0d", k));

      // Yellow: high samples saturate at 255.
      drive(0, 0, 0, 60, 1'b0, 1'b0, 1'b1, 60, "frameStart1");
      for (int k = 0; k < 4; k++)
         drive(7, 7, 0, 60, 1'b1, 1'b0, 1'b0, yellowSeq[k], $sformatf("yellow%0d", k));

      // Blue on zero sync: the low sample clamps at 0 instead of wrapping.
      drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 0, "frameStart2");
      for (int k = 0; k < 4; k++)
         drive(0, 0, 3, 0, 1'b1, 1'b0, 1'b0, blueSeq[k], $sformatf("blue%0d", k));

      drive(0, 0, 0, 60, 1'b0, 1'b0, 1'b0, 60, "blank2");
      drive(0, 0, 0, 60, 1'b0, 1'b0, 1'b0, 60, "blank3");

      // Mid-frame reset: accumulator restarts at phase 0 without frame_start.
      resetPhase(3, "midReset");
      for (int k = 0; k < 4; k++)
         drive(0, 0, 0, 60, 1'b0, 1'b1, 1'b0, burstSeq[k], $sformatf("burstAfterReset%0d", k));
      drive(0, 0, 0, 60, 1'b0, 1'b0, 1'b0, 60, "blank4");
      drive(0, 0, 0, 60, 1'b0, 1'b0, 1'b0, 60, "blank5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
